// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmitter
//   state_t    - transmit FSM state encoding
//   FRAME_BITS - bits per frame (start + 8 data + stop)
//   bit_cycles - clock cycles per serial bit from clock and baud rate
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam int FRAME_BITS = 10;

    function automatic int bit_cycles(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_transmit_if.sv
// uart_transmit_if: byte handshake between a producer and the UART transmitter
//   DataIn      - byte offered by the producer
//   DataInValid - producer offers DataIn this cycle
//   DataInReady - transmitter can take a byte this cycle
//   master modport: producer side; slave modport: transmitter side
interface uart_transmit_if;

    logic [7:0] DataIn;
    logic       DataInValid;
    logic       DataInReady;

    modport master (output DataIn, output DataInValid, input DataInReady);
    modport slave  (input DataIn, input DataInValid, output DataInReady);

endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter producing a one-cycle tick per serial bit
//   clk     - system clock
//   reset_n - asynchronous active-low reset
//   clear   - restart the count from 0 on the next edge
//   tick    - high during the last cycle of each bit period
module uart_baud_tick #(
    parameter int BIT_CYCLES = 434
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(BIT_CYCLES);

    logic [CW-1:0] count;

    assign tick = count == CW'(BIT_CYCLES - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) count <= '0;
        else          count <= (clear || tick) ? '0 : count + CW'(1);
    end

endmodule

// File: rtl/uart_transmit.sv
// uart_transmit: 8N1 UART transmitter with a one-byte holding register
//   clk     - system clock
//   reset_n - asynchronous active-low reset
//   bus     - byte handshake (slave side): DataIn, DataInValid, DataInReady
//   SOut    - serial line, idle high, driven from a flop
//   Busy    - a frame is in progress or a byte is waiting in the hold register
module uart_transmit
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic           clk,
    input  logic           reset_n,
    uart_transmit_if.slave bus,
    output logic           SOut,
    output logic           Busy
);

    localparam int BIT_CYCLES = bit_cycles(CLOCK_FREQ, BAUD_RATE);

    if (BIT_CYCLES < 2) begin : g_bad_rate
        $error("uart_transmit: CLOCK_FREQ / BAUD_RATE must be at least 2");
    end

    state_t                state;
    logic [FRAME_BITS-1:0] shift;
    logic [2:0]            idx;
    logic [7:0]            hold_data;
    logic                  hold_valid;
    logic                  tick;
    logic                  accept;
    logic                  load;

    assign bus.DataInReady = !hold_valid;
    assign accept          = bus.DataInValid && !hold_valid;
    // Hold moves to the shifter from IDLE, or straight at the end of a stop bit
    // so back-to-back frames have no idle gap.
    assign load            = hold_valid && (state == IDLE || (state == STOP && tick));
    assign Busy            = state != IDLE || hold_valid;

    uart_baud_tick #(.BIT_CYCLES(BIT_CYCLES)) u_baud_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (load),
        .tick    (tick)
    );

    // The shifter always presents the current bit in shift[0]; SOut registers it
    // one cycle behind the state so the line never glitches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            shift      <= '1;
            idx        <= '0;
            hold_data  <= '0;
            hold_valid <= 1'b0;
            SOut       <= 1'b1;
        end else begin
            SOut       <= state == IDLE || shift[0];
            hold_valid <= accept || (hold_valid && !load);
            if (accept) hold_data <= bus.DataIn;
            if (load) begin
                shift <= {1'b1, hold_data, 1'b0};
                idx   <= '0;
                state <= START;
            end else if (tick && state != IDLE) begin
                shift <= {1'b1, shift[FRAME_BITS-1:1]};
                case (state)
                    START: begin
                        idx   <= '0;
                        state <= DATA;
                    end
                    DATA: begin
                        if (idx == 3'd7) state <= STOP;
                        else             idx   <= idx + 3'd1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/uart_transmit.md
UART_TRANSMIT -- requirements
Module: uart_transmit

Interface
REQ-001 Parameter CLOCK_FREQ, default 50_000_000, clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115_200, serial bit rate in bits/s.
REQ-003 Derived constant BIT_CYCLES = CLOCK_FREQ / BAUD_RATE, integer division, 434 at defaults; it SHALL be at least 2.
REQ-004 clk  input  1  the single system clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 DataIn  input  8  byte to transmit, qualified by DataInValid.
REQ-007 DataInValid  input  1  producer (UART control path) offers DataIn this cycle.
REQ-008 DataInReady  output  1  block can accept a byte this cycle.
REQ-009 SOut  output  1  serial line, idle high.
REQ-010 Busy  output  1  a frame is on the line or a byte is held.

Function
REQ-011 A byte SHALL be accepted on any rising edge where DataInValid && DataInReady; no other edge accepts.
REQ-012 Storage SHALL be double-buffered: a 1-byte holding register plus a 10-bit shift register (start 0, DataIn[0..7] LSB first, stop 1).
REQ-013 DataInReady SHALL be 1 exactly when the holding register is empty, registered-free (combinational from the hold-valid flag).
REQ-014 States: IDLE, START, DATA, STOP; encoding lives in the shared package.
REQ-015 IDLE: SOut=1; if the hold register is full, on the next edge move the byte to the shift register, clear hold-valid, clear baud counter, go to START.
REQ-016 START: SOut=0 for BIT_CYCLES cycles, then DATA with bit index 0.
REQ-017 DATA: SOut=shift bit; after BIT_CYCLES cycles advance index; after index 7 completes go to STOP.
REQ-018 STOP: SOut=1 for BIT_CYCLES cycles; at its end go to START directly if the hold register is full (loading it as in REQ-015, no idle gap), else IDLE.
REQ-019 Baud counter SHALL count 0..BIT_CYCLES-1 and wrap to 0, generating a one-cycle tick on the terminal count; width = clog2(BIT_CYCLES).
REQ-020 Bit index SHALL be 3 bits, saturating usage at 7; no wrap is permitted to restart DATA.
REQ-021 Latency: first start-bit cycle on SOut SHALL be 2 cycles after the accept edge when IDLE; a full frame lasts exactly 10*BIT_CYCLES cycles.
REQ-022 Simultaneous hold-load into shift and new accept on the same edge SHALL be legal: hold refills with the new byte, the old one is in the shift register, none lost.
REQ-023 DataInValid while DataInReady=0 SHALL be ignored without side effect; DataIn need not be held by the producer.
REQ-024 Busy SHALL be 1 whenever state != IDLE or hold-valid=1.
REQ-025 SOut SHALL be driven from a flop (glitch-free).

Reset
REQ-026 On reset_n=0, immediately and asynchronously: state=IDLE, SOut=1, hold-valid=0, DataInReady=1, Busy=0, counters=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame and discard both buffered bytes; SOut returns high without completing the stop bit.
REQ-028 After reset_n deasserts, first accept SHALL be possible on the first rising edge.

Structure
REQ-029 Shared package uart_pkg SHALL hold the state typedef, the BIT_CYCLES derivation function, and frame-length constant 10.
REQ-030 One sub-module, uart_baud_tick (parameter BIT_CYCLES; inputs clk, reset_n, clear; output tick), SHALL implement REQ-019.
REQ-031 No other hierarchy; no memories; synthesizable flops and logic only.

Verification (CLOCK_FREQ=8, BAUD_RATE=1, so BIT_CYCLES=8)
REQ-032 Single byte 0xA5 accepted from IDLE -> SOut reads 0,1,0,1,0,0,1,0,1,1 each held 8 cycles, start bit 2 cycles after accept, Busy drops after 80 cycles.
REQ-033 Back-to-back 0x00 then 0xFF, second offered immediately after first -> both accepted within 2 cycles, DataInReady low until frame 1 loads byte 2, 160 contiguous bit-cycles with no idle gap.
REQ-034 DataInValid held high with 0x55, 0x66, 0x77 while hold full -> only bytes seen with DataInReady=1 transmitted, no byte dropped or duplicated.
REQ-035 Accept on the same edge the hold register unloads (end of STOP) -> correct order 0x12, 0x34, 0x56 on line.
REQ-036 reset_n pulsed low during DATA bit 3 of 0xC3 with a byte held -> SOut=1 immediately, DataInReady=1, Busy=0, nothing further transmitted.
REQ-037 Default parameters, one byte 0x41 -> each bit exactly 434 cycles, frame 4340 cycles.
